div_rem_pipelined: RTL
======================

# div_rem_pipelined

Parametrised, fully pipelined integer divide/remainder unit for the RISC-V M-extension execute path, successor to the fixed 32-bit unsigned restoring divider. It accepts one DIV/DIVU/REM/REMU operation per cycle and returns the selected result after a fixed latency. The result carries a valid bit and a tag, so the hazard/writeback logic can match results to in-flight instructions. Architectural divide-by-zero and signed-overflow results are produced in hardware.

## Interface
- WIDTH, 32: operand and result width; even, ≥ 8.
- BITS_PER_STAGE, 4: restoring iterations per pipeline stage; must divide WIDTH.
- TAG_W, 5: width of the pass-through tag (e.g. rd index).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  freezes every pipeline stage, including valid and tag.
- i_valid  input  1  operation present this cycle.
- i_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_dividend  input  WIDTH  dividend (rs1).
- i_divisor  input  WIDTH  divisor (rs2).
- i_tag  input  TAG_W  opaque tag, returned with the result.
- o_valid  output  1  result valid.
- o_result  output  WIDTH  quotient or remainder per op; 0 when o_valid=0.
- o_tag  output  TAG_W  tag of the result; 0 when o_valid=0.
- o_div_by_zero  output  1  divisor was 0; qualified by o_valid.

## Operation
- STAGES = WIDTH/BITS_PER_STAGE (8 by default). Each stage runs BITS_PER_STAGE restoring iterations. Per iteration: rem = {rem, dividend MSB}. If rem ≥ divisor, subtract the divisor and shift a 1 into the quotient; otherwise shift in a 0. Then shift the dividend left by 1. The compare uses WIDTH+1 bits.
- Signed ops (00, 10) are handled at entry:
  - Record neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
  - Feed |a| and |b| to the unsigned datapath.
- Unsigned ops feed the operands unchanged and set both flags to 0.
- Each stage register holds: valid, op, tag, the two sign flags, a divzero flag, an overflow flag, the original dividend, the working dividend, the divisor, the remainder and the quotient.
- Output stage is combinational from the last register:
  - Divisor = 0: quotient = all ones, remainder = original dividend, o_div_by_zero = 1.
  - Signed overflow (a = −2^(WIDTH−1), b = −1, signed op): quotient = a, remainder = 0.
  - Otherwise: quotient is negated if neg_q; remainder is negated if neg_r.
  - o_result is the quotient for ops 00/01 and the remainder for ops 10/11.
- While stall=1, i_valid is ignored and the operation is not captured. The upstream stage must hold its request.
- Bubbles (valid=0) still advance through the pipe, with their data zeroed.

## Timing
- An operation captured at edge N appears on the outputs after edge N+STAGES−1, i.e. STAGES cycles after i_valid is sampled with stall=0. Each stalled cycle adds one cycle.
- Throughput is 1 op/cycle with no structural hazards. Back-to-back ops with different i_op values are independent.
- When stall=1, all stage registers hold. The outputs stay constant for the whole stall.
- rst asserted at any time, including mid-operation:
  - Every stage register clears to 0 immediately and in-flight ops are discarded.
  - o_valid=0, o_result=0, o_tag=0, o_div_by_zero=0 until the first valid op has traversed the pipe.
- When rst and stall are both high, reset wins.

## Configuration
- DIV_SIGNED_EN defined:
  - Signed ops 00/10 behave as above.
  - Sign/abs logic, sign flags and overflow detection are present.
- DIV_SIGNED_EN undefined:
  - i_op[0] is ignored: 00 behaves as 01 and 10 behaves as 11.
  - Sign flags, abs/negate logic and overflow detection are removed.
  - The divide-by-zero rule still applies.

## Test plan
- DIVU 100/7, tag 3, no stall → exactly 8 cycles later: o_valid=1, o_result=14, o_tag=3. REMU of the same operands → 2.
- DIV −7/2 → −3 (0xFFFFFFFD). REM −7/2 → −1 (0xFFFFFFFF). REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFFFFFF with o_div_by_zero=1. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0.
- Eight consecutive ops with tags 0–7, stall=1 for 3 cycles mid-stream → results arrive in order with the correct tags, outputs frozen during the stall, total latency for affected ops 11 cycles.
- Assert rst for 1 cycle with 4 ops in flight → o_valid stays 0 for the following 8 cycles; a new op issued after reset completes normally.
- Build without DIV_SIGNED_EN: DIV 0xFFFFFFFE/2 → 0x7FFFFFFF (unsigned semantics).

Source files
------------

// File: rtl/div_rem_pipelined.sv
// rtl/div_rem_pipelined.sv - pipelined DIV/DIVU/REM/REMU unit, one restoring block of BITS_PER_STAGE steps per stage.
// Define DIV_SIGNED_EN to build signed DIV/REM; otherwise i_op[0] is ignored and all ops are unsigned.
module div_rem_pipelined #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 4,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_div_by_zero
);

  localparam int W      = WIDTH;
  localparam int STAGES = WIDTH / BITS_PER_STAGE;

  logic [W-1:0] e_dvd, e_dvs;
  logic         e_dz;
`ifdef DIV_SIGNED_EN
  logic signed_op, a_neg, b_neg, e_neg_q, e_neg_r, e_ovf;

  // The unsigned datapath sees magnitudes; the signs are reapplied at the output.
  assign signed_op = ~i_op[0];
  assign a_neg     = signed_op & i_dividend[W-1];
  assign b_neg     = signed_op & i_divisor[W-1];
  assign e_neg_q   = a_neg ^ b_neg;
  assign e_neg_r   = a_neg;
  assign e_dvd     = a_neg ? -i_dividend : i_dividend;
  assign e_dvs     = b_neg ? -i_divisor : i_divisor;
  assign e_ovf     = signed_op & (i_dividend == {1'b1, {(W-1){1'b0}}}) & (&i_divisor);
`else
  logic unused_op0;

  assign unused_op0 = i_op[0];
  assign e_dvd      = i_dividend;
  assign e_dvs      = i_divisor;
`endif
  assign e_dz = (i_divisor == '0);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_valid, src_is_rem, src_dz;
    logic [TAG_W-1:0] src_tag;
    logic [W-1:0]     src_orig, src_dvd, src_dvs, src_rem, src_quo;
    logic [W-1:0]     nxt_rem, nxt_dvd, nxt_quo;
    logic [W:0]       ext;

    logic             r_valid, r_is_rem, r_dz;
    logic [TAG_W-1:0] r_tag;
    logic [W-1:0]     r_orig, r_dvd, r_dvs, r_rem, r_quo;
`ifdef DIV_SIGNED_EN
    logic             src_neg_q, src_neg_r, src_ovf;
    logic             r_neg_q, r_neg_r, r_ovf;
`endif

    if (k == 0) begin : g_src
      assign src_valid  = i_valid;
      assign src_is_rem = i_op[1];
      assign src_dz     = e_dz;
      assign src_tag    = i_tag;
      assign src_orig   = i_dividend;
      assign src_dvd    = e_dvd;
      assign src_dvs    = e_dvs;
      assign src_rem    = '0;
      assign src_quo    = '0;
`ifdef DIV_SIGNED_EN
      assign src_neg_q  = e_neg_q;
      assign src_neg_r  = e_neg_r;
      assign src_ovf    = e_ovf;
`endif
    end else begin : g_src
      assign src_valid  = g_stage[k-1].r_valid;
      assign src_is_rem = g_stage[k-1].r_is_rem;
      assign src_dz     = g_stage[k-1].r_dz;
      assign src_tag    = g_stage[k-1].r_tag;
      assign src_orig   = g_stage[k-1].r_orig;
      assign src_dvd    = g_stage[k-1].r_dvd;
      assign src_dvs    = g_stage[k-1].r_dvs;
      assign src_rem    = g_stage[k-1].r_rem;
      assign src_quo    = g_stage[k-1].r_quo;
`ifdef DIV_SIGNED_EN
      assign src_neg_q  = g_stage[k-1].r_neg_q;
      assign src_neg_r  = g_stage[k-1].r_neg_r;
      assign src_ovf    = g_stage[k-1].r_ovf;
`endif
    end

    // Restoring steps; after subtraction the remainder is below the divisor, so W bits suffice.
    always_comb begin
      nxt_rem = src_rem;
      nxt_dvd = src_dvd;
      nxt_quo = src_quo;
      ext     = '0;
      for (int i = 0; i < BITS_PER_STAGE; i++) begin
        ext = {nxt_rem, nxt_dvd[W-1]};
        if (ext >= {1'b0, src_dvs}) begin
          nxt_rem = ext[W-1:0] - src_dvs;
          nxt_quo = {nxt_quo[W-2:0], 1'b1};
        end else begin
          nxt_rem = ext[W-1:0];
          nxt_quo = {nxt_quo[W-2:0], 1'b0};
        end
        nxt_dvd = {nxt_dvd[W-2:0], 1'b0};
      end
    end

    // Bubbles travel with all data cleared.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid  <= 1'b0;
        r_is_rem <= 1'b0;
        r_dz     <= 1'b0;
        r_tag    <= '0;
        r_orig   <= '0;
        r_dvd    <= '0;
        r_dvs    <= '0;
        r_rem    <= '0;
        r_quo    <= '0;
`ifdef DIV_SIGNED_EN
        r_neg_q  <= 1'b0;
        r_neg_r  <= 1'b0;
        r_ovf    <= 1'b0;
`endif
      end else if (!stall) begin
        r_valid  <= src_valid;
        r_is_rem <= src_valid & src_is_rem;
        r_dz     <= src_valid & src_dz;
        r_tag    <= src_valid ? src_tag : '0;
        r_orig   <= src_valid ? src_orig : '0;
        r_dvd    <= src_valid ? nxt_dvd : '0;
        r_dvs    <= src_valid ? src_dvs : '0;
        r_rem    <= src_valid ? nxt_rem : '0;
        r_quo    <= src_valid ? nxt_quo : '0;
`ifdef DIV_SIGNED_EN
        r_neg_q  <= src_valid & src_neg_q;
        r_neg_r  <= src_valid & src_neg_r;
        r_ovf    <= src_valid & src_ovf;
`endif
      end
    end
  end

  logic             l_valid, l_is_rem, l_dz;
  logic [TAG_W-1:0] l_tag;
  logic [W-1:0]     l_orig, l_rem, l_quo, fix_q, fix_r;

  assign l_valid  = g_stage[STAGES-1].r_valid;
  assign l_is_rem = g_stage[STAGES-1].r_is_rem;
  assign l_dz     = g_stage[STAGES-1].r_dz;
  assign l_tag    = g_stage[STAGES-1].r_tag;
  assign l_orig   = g_stage[STAGES-1].r_orig;
  assign l_rem    = g_stage[STAGES-1].r_rem;
  assign l_quo    = g_stage[STAGES-1].r_quo;

  always_comb begin
    fix_q = l_quo;
    fix_r = l_rem;
    if (l_dz) begin
      fix_q = '1;
      fix_r = l_orig;
`ifdef DIV_SIGNED_EN
    end else if (g_stage[STAGES-1].r_ovf) begin
      fix_q = l_orig;
      fix_r = '0;
    end else begin
      if (g_stage[STAGES-1].r_neg_q) fix_q = -l_quo;
      if (g_stage[STAGES-1].r_neg_r) fix_r = -l_rem;
`endif
    end
  end

  assign o_valid       = l_valid;
  assign o_result      = l_valid ? (l_is_rem ? fix_r : fix_q) : '0;
  assign o_tag         = l_valid ? l_tag : '0;
  assign o_div_by_zero = l_valid & l_dz;

endmodule
